// File: rtl/counter_ctrl.sv
// Bus-side command/response controller and interrupt qualifier for the counter core.
// One command in flight: accept, one ACCESS cycle of strobes, then RESP held until rspReady.
module counter_ctrl #(
    parameter int IRQ_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    // command / response stream
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic [1:0]           cmdOp,
    input  logic [31:0]          cmdData,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [31:0]          rspData,
    // core register side
    output logic [31:0]          counterIn,
    output logic                 counterEnIn,
    output logic                 counterDirIn,
    output logic                 counterIreIn,
    output logic                 counterWe,
    output logic                 counterConfigWe,
    output logic                 counterRe,
    output logic                 counterConfigRe,
    output logic                 counterStatusRe,
    input  logic [31:0]          counterOut,
    input  logic                 counterEnOut,
    input  logic                 counterDirOut,
    input  logic                 counterIreOut,
    input  logic                 counterLT1000Out,
    // interrupt side
    input  logic                 counterIrq,
    output logic                 irqPending,
    output logic [IRQ_CNT_W-1:0] irqCount,
    input  logic                 irqAck
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_WR_CNT = 2'b00;
    localparam logic [1:0] OP_WR_CFG = 2'b01;
    localparam logic [1:0] OP_RD_CNT = 2'b10;
    localparam logic [1:0] OP_RD_STS = 2'b11;

    localparam logic [IRQ_CNT_W-1:0] IRQ_CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          rsp_q, rsp_d;

    logic                 irq_prev_q;
    logic                 irq_pend_q, irq_pend_d;
    logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
    logic                 irq_event;

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        data_d          = data_q;
        rsp_d           = rsp_q;
        cmdReady        = 1'b0;
        counterWe       = 1'b0;
        counterConfigWe = 1'b0;
        counterRe       = 1'b0;
        counterConfigRe = 1'b0;
        counterStatusRe = 1'b0;

        case (state_q)
            IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    op_d    = cmdOp;
                    data_d  = cmdData;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                case (op_q)
                    OP_WR_CNT: begin
                        counterWe = 1'b1;
                        rsp_d     = data_q;
                    end
                    OP_WR_CFG: begin
                        counterConfigWe = 1'b1;
                        rsp_d           = data_q;
                    end
                    OP_RD_CNT: begin
                        counterRe = 1'b1;
                        rsp_d     = counterOut;
                    end
                    OP_RD_STS: begin
                        counterConfigRe = 1'b1;
                        counterStatusRe = 1'b1;
                        rsp_d = {28'b0, counterLT1000Out, counterIreOut,
                                 counterDirOut, counterEnOut};
                    end
                    default: ;
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            data_q  <= 32'h0;
            rsp_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
        end
    end

    // Core write data is the latched command word, held between commands.
    assign counterIn    = data_q;
    assign counterEnIn  = data_q[0];
    assign counterDirIn = data_q[1];
    assign counterIreIn = data_q[2];

    assign rspValid = (state_q == RESP);
    assign rspData  = rsp_q;

    // ------------------------------------------------------------------
    // Interrupt qualification: rising edge of the level, gated by IRE
    // ------------------------------------------------------------------
    assign irq_event = counterIrq & ~irq_prev_q & counterIreOut;

    always_comb begin
        irq_pend_d = irq_pend_q;
        irq_cnt_d  = irq_cnt_q;
        if (irqAck) begin
            // an event coincident with the ack survives as the first of a new batch
            irq_pend_d = irq_event;
            irq_cnt_d  = irq_event ? IRQ_CNT_W'(1) : '0;
        end else if (irq_event) begin
            irq_pend_d = 1'b1;
            if (irq_cnt_q != IRQ_CNT_MAX) begin
                irq_cnt_d = irq_cnt_q + IRQ_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_cnt_q  <= '0;
        end else begin
            irq_prev_q <= counterIrq;
            irq_pend_q <= irq_pend_d;
            irq_cnt_q  <= irq_cnt_d;
        end
    end

    assign irqPending = irq_pend_q;
    assign irqCount   = irq_cnt_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: behavioural counter core, spec-level interrupt model,
// directed scenarios plus a randomized command/interrupt run.
module tb_counter_ctrl;

    localparam int IRQ_W = 8;
    localparam int IMAX  = (1 << IRQ_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmdValid, cmdReady;
    logic [1:0]       cmdOp;
    logic [31:0]      cmdData;
    logic             rspValid, rspReady;
    logic [31:0]      rspData;
    logic [31:0]      counterIn;
    logic             counterEnIn, counterDirIn, counterIreIn;
    logic             counterWe, counterConfigWe, counterRe, counterConfigRe, counterStatusRe;
    logic [31:0]      counterOut;
    logic             counterEnOut, counterDirOut, counterIreOut, counterLT1000Out;
    logic             counterIrq;
    logic             irqPending;
    logic [IRQ_W-1:0] irqCount;
    logic             irqAck;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.IRQ_CNT_W(IRQ_W)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdData(cmdData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .counterIn(counterIn), .counterEnIn(counterEnIn), .counterDirIn(counterDirIn),
        .counterIreIn(counterIreIn), .counterWe(counterWe), .counterConfigWe(counterConfigWe),
        .counterRe(counterRe), .counterConfigRe(counterConfigRe), .counterStatusRe(counterStatusRe),
        .counterOut(counterOut), .counterEnOut(counterEnOut), .counterDirOut(counterDirOut),
        .counterIreOut(counterIreOut), .counterLT1000Out(counterLT1000Out),
        .counterIrq(counterIrq), .irqPending(irqPending), .irqCount(irqCount), .irqAck(irqAck)
    );

    // Behavioural counter core: stops and raises its irq level at 0xFFFF when counting up.
    logic [31:0] core_cnt;
    logic        core_en, core_dir, core_ire;
    logic        irq_frc_en, irq_frc;

    always @(posedge clk) begin
        if (reset) begin
            core_cnt <= 32'h0;
            core_en  <= 1'b0;
            core_dir <= 1'b0;
            core_ire <= 1'b0;
        end else begin
            if (counterWe)
                core_cnt <= counterIn;
            else if (core_en) begin
                if (core_dir) begin
                    if (core_cnt == 32'hFFFF) core_en <= 1'b0;
                    else core_cnt <= core_cnt + 32'd1;
                end else
                    core_cnt <= core_cnt - 32'd1;
            end
            if (counterConfigWe) begin
                core_en  <= counterEnIn;
                core_dir <= counterDirIn;
                core_ire <= counterIreIn;
            end
        end
    end

    assign counterOut       = core_cnt;
    assign counterEnOut     = core_en;
    assign counterDirOut    = core_dir;
    assign counterIreOut    = core_ire;
    assign counterLT1000Out = (core_cnt < 32'd1000);
    assign counterIrq       = irq_frc_en ? irq_frc : (core_cnt == 32'hFFFF);

    // Interrupt reference: count rising edges seen with IRE set, saturate, ack clears.
    int m_icnt;
    bit m_ipend, m_iprev, m_ev;

    always @(posedge clk) begin
        if (reset) begin
            m_icnt = 0; m_ipend = 0; m_iprev = 0;
        end else begin
            m_ev = counterIrq && !m_iprev && counterIreOut;
            if (irqAck) begin
                m_icnt  = m_ev ? 1 : 0;
                m_ipend = m_ev;
            end else if (m_ev) begin
                m_ipend = 1;
                if (m_icnt < IMAX) m_icnt = m_icnt + 1;
            end
            m_iprev = counterIrq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] stb_now();
        return {counterWe, counterConfigWe, counterRe, counterConfigRe, counterStatusRe};
    endfunction

    function automatic logic [4:0] stb_for(input logic [1:0] op);
        case (op)
            2'b00:   return 5'b10000;
            2'b01:   return 5'b01000;
            2'b10:   return 5'b00100;
            default: return 5'b00011;
        endcase
    endfunction

    // Drives one command and returns observations; all judging is done by the callers.
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] d, input int hold,
                          output logic [31:0] rsp, output logic [4:0] stb_acc,
                          output int stb_cycles, output int lat, output bit to);
        int n;
        to = 0; rsp = '0; stb_acc = '0; stb_cycles = 0; lat = 0;
        n = 0;
        while (!cmdReady && n < 20) begin tick(); n++; end
        if (!cmdReady) begin to = 1; return; end
        cmdValid = 1'b1; cmdOp = op; cmdData = d;
        tick();
        cmdValid = 1'b0;
        stb_acc = stb_now();
        lat = 1;
        while (!rspValid && lat < 10) begin
            if (|stb_now()) stb_cycles++;
            tick(); lat++;
        end
        if (!rspValid) begin to = 1; return; end
        for (int i = 0; i < hold; i++) begin
            if (|stb_now()) stb_cycles++;
            tick();
        end
        rsp = rspData;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (cmdReady !== 1'b1 || rspValid !== 1'b0 || rspData !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: cmdReady=%b rspValid=%b rspData=%h required 1 0 0", cmdReady, rspValid, rspData);
        end
        checks++;
        if (stb_now() !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b required 00000", stb_now());
        end
        checks++;
        if (counterIn !== 32'h0 || {counterEnIn, counterDirIn, counterIreIn} !== 3'b000) begin
            failures++;
            $display("FAIL reset_core_in: counterIn=%h cfg=%b required 0 000", counterIn,
                     {counterEnIn, counterDirIn, counterIreIn});
        end
        checks++;
        if (irqPending !== 1'b0 || irqCount !== 8'd0) begin
            failures++;
            $display("FAIL reset_irq: pending=%b count=%0d required 0 0", irqPending, irqCount);
        end
        // commands offered during reset are ignored
        cmdValid = 1'b1; cmdOp = 2'b00; cmdData = 32'hABCD;
        repeat (2) tick();
        cmdValid = 1'b0;
        checks++;
        if (counterWe !== 1'b0 || counterIn !== 32'h0 || rspValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ignores_cmd: We=%b In=%h rspValid=%b required 0 0 0", counterWe, counterIn, rspValid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_count();
        logic [31:0] r; logic [4:0] s; int sc, lat; bit to;
        do_cmd(2'b00, 32'h0000_1234, 0, r, s, sc, lat, to);
        checks++;
        if (to || lat != 2) begin
            failures++;
            $display("FAIL wrcnt_latency: timeout=%0d latency=%0d required 0 2", to, lat);
        end
        checks++;
        if (s !== 5'b10000 || sc != 1) begin
            failures++;
            $display("FAIL wrcnt_strobe: strobes=%b cycles=%0d required 10000 1", s, sc);
        end
        checks++;
        if (r !== 32'h0000_1234) begin
            failures++;
            $display("FAIL wrcnt_rsp: got %h required 00001234", r);
        end
        checks++;
        if (core_cnt !== 32'h0000_1234) begin
            failures++;
            $display("FAIL wrcnt_core: got %h required 00001234", core_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit stable_ok = 1;
        int n = 0;
        while (!cmdReady && n < 20) begin tick(); n++; end
        cmdValid = 1'b1; cmdOp = 2'b10; cmdData = 32'h0;
        tick();
        cmdValid = 1'b0;
        tick();
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'h0000_1234) begin
            failures++;
            $display("FAIL bp_rdcnt: rspValid=%b rspData=%h required 1 00001234", rspValid, rspData);
        end
        // second command offered while the response is stalled
        cmdValid = 1'b1; cmdOp = 2'b00; cmdData = 32'h0000_DEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rspValid !== 1'b1 || rspData !== 32'h0000_1234 || cmdReady !== 1'b0 || counterWe !== 1'b0)
                stable_ok = 0;
        end
        checks++;
        if (!stable_ok) begin
            failures++;
            $display("FAIL bp_hold: last rspValid=%b rspData=%h cmdReady=%b We=%b required 1 00001234 0 0",
                     rspValid, rspData, cmdReady, counterWe);
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checks++;
        if (cmdReady !== 1'b1 || rspValid !== 1'b0 || counterWe !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: cmdReady=%b rspValid=%b We=%b required 1 0 0", cmdReady, rspValid, counterWe);
        end
        tick();
        cmdValid = 1'b0;
        checks++;
        if (counterWe !== 1'b1 || counterIn !== 32'h0000_DEAD) begin
            failures++;
            $display("FAIL bp_second_accept: We=%b In=%h required 1 0000dead", counterWe, counterIn);
        end
        tick();
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checks++;
        if (core_cnt !== 32'h0000_DEAD) begin
            failures++;
            $display("FAIL bp_core: got %h required 0000dead", core_cnt);
        end
    endtask

    task automatic test_config_status();
        logic [31:0] r; logic [4:0] s; int sc, lat; bit to;
        do_cmd(2'b00, 32'd500, 0, r, s, sc, lat, to);
        do_cmd(2'b01, 32'h7, 0, r, s, sc, lat, to);
        checks++;
        if (s !== 5'b01000 || r !== 32'h7 || {core_en, core_dir, core_ire} !== 3'b111) begin
            failures++;
            $display("FAIL wrcfg: strobes=%b rsp=%h core=%b required 01000 00000007 111", s, r,
                     {core_en, core_dir, core_ire});
        end
        do_cmd(2'b11, 32'h0, 0, r, s, sc, lat, to);
        checks++;
        if (s !== 5'b00011 || sc != 1) begin
            failures++;
            $display("FAIL rdsts_strobe: strobes=%b cycles=%0d required 00011 1", s, sc);
        end
        checks++;
        if (r !== 32'h0000_000F) begin
            failures++;
            $display("FAIL rdsts_rsp: got %h required 0000000f", r);
        end
        do_cmd(2'b01, 32'h0, 0, r, s, sc, lat, to);
    endtask

    task automatic test_irq_crossing();
        logic [31:0] r; logic [4:0] s; int sc, lat; bit to;
        do_cmd(2'b00, 32'h0000_FFFD, 0, r, s, sc, lat, to);
        do_cmd(2'b01, 32'h7, 0, r, s, sc, lat, to);
        repeat (10) tick();
        checks++;
        if (irqCount !== 8'd1 || irqPending !== 1'b1) begin
            failures++;
            $display("FAIL irq_cross_ire1: count=%0d pending=%b required 1 1", irqCount, irqPending);
        end
        checks++;
        if (int'(irqCount) != m_icnt || irqPending !== m_ipend) begin
            failures++;
            $display("FAIL irq_cross_model: count=%0d pending=%b required %0d %0d", irqCount, irqPending, m_icnt, m_ipend);
        end
        irqAck = 1'b1; tick(); irqAck = 1'b0;
        checks++;
        if (irqCount !== 8'd0 || irqPending !== 1'b0) begin
            failures++;
            $display("FAIL irq_ack: count=%0d pending=%b required 0 0", irqCount, irqPending);
        end
        do_cmd(2'b01, 32'h0, 0, r, s, sc, lat, to);
        do_cmd(2'b00, 32'h0000_FFFD, 0, r, s, sc, lat, to);
        do_cmd(2'b01, 32'h3, 0, r, s, sc, lat, to);
        repeat (10) tick();
        checks++;
        if (irqCount !== 8'd0 || irqPending !== 1'b0 || core_cnt !== 32'hFFFF) begin
            failures++;
            $display("FAIL irq_cross_ire0: count=%0d pending=%b core=%h required 0 0 0000ffff",
                     irqCount, irqPending, core_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] r; logic [4:0] s; int sc, lat; bit to;
        do_cmd(2'b01, 32'h4, 0, r, s, sc, lat, to);
        irq_frc_en = 1'b1; irq_frc = 1'b0;
        tick();
        irqAck = 1'b1; tick(); irqAck = 1'b0;
        for (int i = 0; i < 256; i++) begin
            irq_frc = 1'b1; tick();
            irq_frc = 1'b0; tick();
        end
        checks++;
        if (irqCount !== 8'd255 || irqPending !== 1'b1) begin
            failures++;
            $display("FAIL irq_saturate: count=%0d pending=%b required 255 1", irqCount, irqPending);
        end
        irq_frc = 1'b1; irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
        checks++;
        if (irqCount !== 8'd1 || irqPending !== 1'b1) begin
            failures++;
            $display("FAIL irq_ack_with_edge: count=%0d pending=%b required 1 1", irqCount, irqPending);
        end
        irq_frc = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit no_rsp = 1;
        int n = 0;
        while (!cmdReady && n < 20) begin tick(); n++; end
        cmdValid = 1'b1; cmdOp = 2'b01; cmdData = 32'h5;
        tick();
        cmdValid = 1'b0;
        checks++;
        if (counterConfigWe !== 1'b1 || counterEnIn !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_access: ConfigWe=%b EnIn=%b required 1 1", counterConfigWe, counterEnIn);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (stb_now() !== 5'b0 || rspValid !== 1'b0 || cmdReady !== 1'b1 || rspData !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_fsm: strobes=%b rspValid=%b cmdReady=%b rspData=%h required 00000 0 1 0",
                     stb_now(), rspValid, cmdReady, rspData);
        end
        checks++;
        if (counterIn !== 32'h0 || {counterEnIn, counterDirIn, counterIreIn} !== 3'b0 ||
            irqCount !== 8'd0 || irqPending !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs: In=%h cfg=%b irqCount=%0d pending=%b required 0 000 0 0",
                     counterIn, {counterEnIn, counterDirIn, counterIreIn}, irqCount, irqPending);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rspValid !== 1'b0) no_rsp = 0;
        end
        checks++;
        if (!no_rsp) begin
            failures++;
            $display("FAIL rstmid_no_rsp: rspValid seen=1 required 0");
        end
    endtask

    task automatic test_random();
        logic [31:0] r, d, exp; logic [4:0] s; int sc, lat; bit to;
        logic [1:0] op;
        logic [31:0] mcnt = 32'h0;
        logic [2:0]  mcfg = 3'b000;
        bit done = 0;
        irq_frc_en = 1'b1; irq_frc = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    op = 2'($urandom_range(0, 3));
                    d  = (op == 2'b00) ? 32'($urandom_range(0, 2000)) : ($urandom & 32'hFFFF_FFFE);
                    case (op)
                        2'b10:   exp = mcnt;
                        2'b11:   exp = {28'b0, mcnt < 32'd1000, mcfg[2], mcfg[1], mcfg[0]};
                        default: exp = d;
                    endcase
                    do_cmd(op, d, $urandom_range(0, 3), r, s, sc, lat, to);
                    if (op == 2'b00) mcnt = d;
                    if (op == 2'b01) mcfg = d[2:0];
                    checks++;
                    if (to || lat != 2 || s !== stb_for(op) || sc != 1) begin
                        failures++;
                        $display("FAIL rnd_handshake[%0d]: op=%0d to=%0d lat=%0d strobes=%b cycles=%0d required 0 2 %b 1",
                                 i, op, to, lat, s, sc, stb_for(op));
                    end
                    checks++;
                    if (r !== exp) begin
                        failures++;
                        $display("FAIL rnd_rsp[%0d]: op=%0d got %h required %h", i, op, r, exp);
                    end
                    checks++;
                    if (int'(irqCount) != m_icnt || irqPending !== m_ipend) begin
                        failures++;
                        $display("FAIL rnd_irq[%0d]: count=%0d pending=%b required %0d %0d",
                                 i, irqCount, irqPending, m_icnt, m_ipend);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) begin
                        irq_frc = 1'($urandom_range(0, 1));
                        irqAck  = ($urandom_range(0, 7) == 0);
                    end
                end
                irqAck = 1'b0;
            end
        join
    endtask

    initial begin
        reset = 1'b1; cmdValid = 1'b0; cmdOp = 2'b00; cmdData = 32'h0;
        rspReady = 1'b0; irqAck = 1'b0; irq_frc_en = 1'b0; irq_frc = 1'b0;
        test_reset();
        test_write_count();
        test_backpressure();
        test_config_status();
        test_irq_crossing();
        test_saturation();
        irq_frc = 1'b1; tick(); irq_frc = 1'b0; tick();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
